pgm_stream_sch: RTL and testbench
=================================

// Module: pgm_stream_sch
// PURPOSE
//  Scheduler in front of pgm_rd_pkt_send: shares the single packet-read datapath between 4 template
//  streams stored in pgm_ram at bases 0/128/256/384. Round-robin arbitration among eligible streams,
//  per-stream inter-packet gap (cycles) and packet quota, one packet in flight at a time.
//  Drives sent_pkt_addr/sent_pkt_rd; completion taken from the datapath's out_pgm_data_valid_wr pulse.
// PARAMETERS
//  PLATFORM     "xilinx"  target vendor tag, no functional effect
//  WDOG_CYCLES  1023      max cycles WAIT may last before forced abort (10-bit counter)
// PORTS
//  clk               in   1    clock
//  rst_n             in   1    reset, asynchronous, active-low
//  pgm_config_reset  in   1    sync clear of counters/gaps/done flags (from lcm)
//  stream_en         in   4    per-stream enable, bit i = stream i
//  cfg_gap           in   128  gap of stream i in [32*i+31:32*i], cycles issue-to-issue
//  cfg_pkt_num       in   128  quota of stream i in [32*i+31:32*i]; 0 = unlimited
//  in_pgm_data_ready in   1    downstream (FPGA OS) can accept a packet
//  pkt_done          in   1    1-cycle pulse at packet end (out_pgm_data_valid_wr)
//  sent_pkt_addr     out  10   base address of granted stream, {i[1:0],7'b0}
//  sent_pkt_rd       out  1    1-cycle start pulse to pgm_rd_pkt_send
//  grant_stream      out  2    index of last/current granted stream
//  sch_busy          out  1    1 while a packet is in flight (state WAIT)
//  stream_done       out  4    bit i set when stream i issued cfg_pkt_num packets
//  sch_err           out  1    sticky watchdog-timeout flag
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; gap counters 0; issued counters 0; rr pointer 3 (stream 0 first).
//  eligible[i] = stream_en[i] & gap_cnt[i]==0 & ~stream_done[i].
//  FSM (2 states):
//   IDLE: if in_pgm_data_ready & |eligible: pick first eligible after rr pointer (i+1..i+4 mod 4);
//         next edge: sent_pkt_rd=1, sent_pkt_addr={g,7'b0}, grant_stream=g, rr ptr=g,
//         gap_cnt[g]<=cfg_gap[g], issued[g]++, sch_busy=1, -> WAIT. Else stay, sent_pkt_rd=0.
//   WAIT: sent_pkt_rd=0; sent_pkt_addr held stable (datapath counters sample it).
//         pkt_done -> IDLE next edge, sch_busy=0. Earliest next issue: 1 cycle after return to IDLE.
//         wdog counter reaches WDOG_CYCLES without pkt_done -> IDLE, sch_err<=1 (sticky to rst_n).
//  sent_pkt_addr never cleared between packets; only changes on a grant.
//  Gap counters: decrement by 1 each cycle, saturate at 0; loaded on grant (so gap is issue-to-issue;
//   gap shorter than packet length = back-to-back). cfg_gap=0 -> eligible immediately.
//  Quota: when cfg_pkt_num[i]!=0 and issued[i]==cfg_pkt_num[i] -> stream_done[i]=1 (registered,
//   same edge as the issuing grant). Unlimited: issued[i] 32-bit wraps silently.
//  Quota lowered below issued[i]: done set when issued[i]>=cfg_pkt_num[i] (compare >=).
//  stream_en[i] deasserted: no new grants to i; in-flight packet completes normally.
//  in_pgm_data_ready sampled only in IDLE; drop during WAIT ignored (no abort mid-packet).
//  pkt_done while IDLE: ignored. pkt_done same cycle as grant decision: impossible (WAIT only).
//  pgm_config_reset=1: issued, gap_cnt, stream_done cleared, no new grant that cycle;
//   state/addr/sch_busy untouched -> an in-flight packet finishes; sch_err not cleared.
//  rst_n low mid-packet: immediate return to reset values; datapath reset by same rst_n.
// TESTING
//  1 Reset -> all outputs 0; en=4'b0001, gap=0, ready=1 -> rd pulse 1 cycle later, addr=0, busy=1.
//  2 en=4'b1111, gap=0, pkt_done 8 cyc after each rd -> grant order 0,1,2,3,0; addr 0,128,256,384,0.
//  3 en=4'b0001, gap=100, pkt len 8 -> consecutive rd pulses exactly 100 cycles apart.
//  4 en=4'b0011, quota0=2, quota1=0 -> stream0 issues 2 then stream_done=0001; stream1 continues.
//  5 ready=0 in IDLE -> no rd; ready drop while busy -> packet finishes, no new rd until ready=1.
//  6 No pkt_done for 1023 cycles -> IDLE, sch_err=1; config_reset mid-WAIT -> counters 0, busy held.

Source files
------------

// File: rtl/pgm_stream_sch.sv
// pgm_stream_sch: round-robin scheduler sharing the packet-read datapath between
// four template streams (pgm_ram bases 0/128/256/384), with per-stream
// issue-to-issue gap, packet quota, one packet in flight and a WAIT watchdog.
module pgm_stream_sch #(
    parameter string       PLATFORM    = "xilinx",
    parameter int unsigned WDOG_CYCLES = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pgm_config_reset,
    input  logic [3:0]    stream_en,
    input  logic [127:0]  cfg_gap,
    input  logic [127:0]  cfg_pkt_num,
    input  logic          in_pgm_data_ready,
    input  logic          pkt_done,
    output logic [9:0]    sent_pkt_addr,
    output logic          sent_pkt_rd,
    output logic [1:0]    grant_stream,
    output logic          sch_busy,
    output logic [3:0]    stream_done,
    output logic          sch_err
);

    localparam int unsigned N_STREAM = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned WDOG_W   = 10;

    // Vendor tag only; no vendor-specific structure is generated.
    if (PLATFORM != "xilinx") begin : g_generic_platform
    end

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [WDOG_W-1:0]      wdog;
    logic [CNT_W-1:0]       gap_cnt    [N_STREAM];
    logic [CNT_W-1:0]       issued     [N_STREAM];

    logic [N_STREAM-1:0]    eligible_c;
    logic                   found_c;
    logic                   grant_c;
    logic [IDX_W-1:0]       pick_c;
    logic [IDX_W-1:0]       idx_c;
    logic [CNT_W-1:0]       issued_nxt_c [N_STREAM];
    logic [N_STREAM-1:0]    quota_hit_c;

    // Eligibility and round-robin pick: first eligible stream after rr_ptr.
    always_comb begin
        eligible_c = '0;
        found_c    = 1'b0;
        pick_c     = rr_ptr;
        idx_c      = '0;
        for (int i = 0; i < N_STREAM; i++) begin
            eligible_c[i] = stream_en[i] & (gap_cnt[i] == '0) & ~stream_done[i];
        end
        for (int unsigned k = 1; k <= N_STREAM; k++) begin
            idx_c = rr_ptr + IDX_W'(k);
            if (!found_c && eligible_c[idx_c]) begin
                pick_c  = idx_c;
                found_c = 1'b1;
            end
        end
        grant_c = (state == IDLE) & in_pgm_data_ready & found_c & ~pgm_config_reset;
    end

    // Issue count after this edge, and quota reached (>= so a lowered quota still ends the stream).
    always_comb begin
        quota_hit_c = '0;
        for (int i = 0; i < N_STREAM; i++) begin
            issued_nxt_c[i] = issued[i];
            if (grant_c && (pick_c == IDX_W'(i))) begin
                issued_nxt_c[i] = issued[i] + CNT_W'(1);
            end
            quota_hit_c[i] = (cfg_pkt_num[i*CNT_W +: CNT_W] != '0) &&
                             (issued_nxt_c[i] >= cfg_pkt_num[i*CNT_W +: CNT_W]);
        end
    end

    // Per-stream gap/issue/done bookkeeping. The gap counter is loaded with
    // cfg_gap-1 so that with the one-cycle decision latency, consecutive
    // grants of a stream land exactly cfg_gap cycles apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STREAM; i++) begin
                gap_cnt[i] <= '0;
                issued[i]  <= '0;
            end
            stream_done <= '0;
        end else if (pgm_config_reset) begin
            for (int i = 0; i < N_STREAM; i++) begin
                gap_cnt[i] <= '0;
                issued[i]  <= '0;
            end
            stream_done <= '0;
        end else begin
            for (int i = 0; i < N_STREAM; i++) begin
                if (grant_c && (pick_c == IDX_W'(i))) begin
                    gap_cnt[i] <= (cfg_gap[i*CNT_W +: CNT_W] == '0) ? '0
                                  : cfg_gap[i*CNT_W +: CNT_W] - CNT_W'(1);
                end else if (gap_cnt[i] != '0) begin
                    gap_cnt[i] <= gap_cnt[i] - CNT_W'(1);
                end
                issued[i] <= issued_nxt_c[i];
            end
            stream_done <= stream_done | quota_hit_c;
        end
    end

    // Issue/wait FSM with registered datapath handshake and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sent_pkt_rd   <= 1'b0;
            sent_pkt_addr <= '0;
            grant_stream  <= '0;
            sch_busy      <= 1'b0;
            sch_err       <= 1'b0;
            rr_ptr        <= IDX_W'(N_STREAM - 1);
            wdog          <= '0;
        end else begin
            sent_pkt_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        sent_pkt_rd   <= 1'b1;
                        sent_pkt_addr <= ADDR_W'({pick_c, 7'b0});
                        grant_stream  <= pick_c;
                        rr_ptr        <= pick_c;
                        sch_busy      <= 1'b1;
                        wdog          <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (pkt_done) begin
                        sch_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
                        sch_busy <= 1'b0;
                        sch_err  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pgm_stream_sch.sv
// Directed self-checking bench for pgm_stream_sch.
module tb_pgm_stream_sch;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pgm_config_reset;
    logic [3:0]    stream_en;
    logic [127:0]  cfg_gap;
    logic [127:0]  cfg_pkt_num;
    logic          in_pgm_data_ready;
    logic          pkt_done;
    logic [9:0]    sent_pkt_addr;
    logic          sent_pkt_rd;
    logic [1:0]    grant_stream;
    logic          sch_busy;
    logic [3:0]    stream_done;
    logic          sch_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic resp_en = 1'b1;
    int   pkt_len = 8;
    int   resp_cnt = 0;

    pgm_stream_sch #(.PLATFORM("xilinx"), .WDOG_CYCLES(1023)) dut (
        .clk(clk), .rst_n(rst_n), .pgm_config_reset(pgm_config_reset),
        .stream_en(stream_en), .cfg_gap(cfg_gap), .cfg_pkt_num(cfg_pkt_num),
        .in_pgm_data_ready(in_pgm_data_ready), .pkt_done(pkt_done),
        .sent_pkt_addr(sent_pkt_addr), .sent_pkt_rd(sent_pkt_rd),
        .grant_stream(grant_stream), .sch_busy(sch_busy),
        .stream_done(stream_done), .sch_err(sch_err)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: pulses pkt_done pkt_len cycles after each rd pulse.
    initial begin
        pkt_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pkt_done = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) pkt_done = 1'b1;
            end else if (resp_en && sent_pkt_rd) begin
                resp_cnt = pkt_len;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until the next rd pulse (sampled after the edge it appears on).
    task automatic wait_rd(input int max_cyc, output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc && !ok) begin
            tick();
            cyc++;
            if (sent_pkt_rd) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc && !ok) begin
            tick();
            cyc++;
            if (!sch_busy) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        stream_en         = 4'b0000;
        in_pgm_data_ready = 1'b0;
        pgm_config_reset  = 1'b0;
        repeat (12) tick();
        rst_n       = 1'b0;
        cfg_gap     = '0;
        cfg_pkt_num = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int   cyc;
        logic ok;
        int   exp_g [5];
        int   exp_g4 [6];
        int   rd_cnt;

        rst_n = 1'b0;
        pgm_config_reset = 1'b0;
        stream_en = '0;
        cfg_gap = '0;
        cfg_pkt_num = '0;
        in_pgm_data_ready = 1'b0;
        repeat (3) tick();

        // 1: reset values, then first issue one cycle after request
        check("rst_addr", 32'(sent_pkt_addr), 0);
        check("rst_rd", 32'(sent_pkt_rd), 0);
        check("rst_grant", 32'(grant_stream), 0);
        check("rst_busy", 32'(sch_busy), 0);
        check("rst_done", 32'(stream_done), 0);
        check("rst_err", 32'(sch_err), 0);
        rst_n = 1'b1;
        tick();
        stream_en = 4'b0001;
        in_pgm_data_ready = 1'b1;
        wait_rd(20, cyc, ok);
        check("t1_rd_seen", 32'(ok), 1);
        check("t1_latency", 32'(cyc), 1);
        check("t1_addr", 32'(sent_pkt_addr), 0);
        check("t1_busy", 32'(sch_busy), 1);
        tick();
        check("t1_rd_one_cycle", 32'(sent_pkt_rd), 0);
        check("t1_busy_held", 32'(sch_busy), 1);

        // 2: round-robin across all four streams, packets 8 cycles long
        do_reset();
        stream_en = 4'b1111;
        in_pgm_data_ready = 1'b1;
        exp_g = '{0, 1, 2, 3, 0};
        for (int n = 0; n < 5; n++) begin
            wait_rd(40, cyc, ok);
            check($sformatf("t2_rd_seen%0d", n), 32'(ok), 1);
            check($sformatf("t2_grant%0d", n), 32'(grant_stream), 32'(exp_g[n]));
            check($sformatf("t2_addr%0d", n), 32'(sent_pkt_addr), 32'(exp_g[n] * 128));
            if (n > 0) check($sformatf("t2_spacing%0d", n), 32'(cyc), 10);
        end

        // 3: issue-to-issue gap of 100 cycles
        do_reset();
        cfg_gap[31:0] = 32'd100;
        stream_en = 4'b0001;
        in_pgm_data_ready = 1'b1;
        wait_rd(20, cyc, ok);
        check("t3_first", 32'(cyc), 1);
        for (int n = 0; n < 2; n++) begin
            wait_rd(200, cyc, ok);
            check($sformatf("t3_rd_seen%0d", n), 32'(ok), 1);
            check($sformatf("t3_gap%0d", n), 32'(cyc), 100);
        end

        // 4: quota of 2 on stream 0, stream 1 unlimited
        do_reset();
        cfg_pkt_num[31:0] = 32'd2;
        stream_en = 4'b0011;
        in_pgm_data_ready = 1'b1;
        exp_g4 = '{0, 1, 0, 1, 1, 1};
        for (int n = 0; n < 6; n++) begin
            wait_rd(40, cyc, ok);
            check($sformatf("t4_rd_seen%0d", n), 32'(ok), 1);
            check($sformatf("t4_grant%0d", n), 32'(grant_stream), 32'(exp_g4[n]));
            check($sformatf("t4_done%0d", n), 32'(stream_done), (n >= 2) ? 32'd1 : 32'd0);
        end

        // 5: ready gating in IDLE, ready drop during a packet ignored
        do_reset();
        stream_en = 4'b0001;
        rd_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (sent_pkt_rd) rd_cnt++;
        end
        check("t5_no_rd_not_ready", 32'(rd_cnt), 0);
        in_pgm_data_ready = 1'b1;
        wait_rd(20, cyc, ok);
        check("t5_rd_after_ready", 32'(cyc), 1);
        in_pgm_data_ready = 1'b0;
        wait_idle(40, cyc, ok);
        check("t5_pkt_finished", 32'(ok), 1);
        check("t5_busy_len", 32'(cyc), 9);
        rd_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (sent_pkt_rd) rd_cnt++;
        end
        check("t5_no_rd_after_drop", 32'(rd_cnt), 0);
        in_pgm_data_ready = 1'b1;
        wait_rd(20, cyc, ok);
        check("t5_rd_resume", 32'(cyc), 1);

        // 6: config reset during WAIT, then watchdog abort
        resp_en = 1'b0;
        do_reset();
        cfg_pkt_num[31:0] = 32'd1;
        stream_en = 4'b0001;
        in_pgm_data_ready = 1'b1;
        wait_rd(20, cyc, ok);
        check("t6_rd", 32'(ok), 1);
        check("t6_done_set", 32'(stream_done), 1);
        repeat (4) tick();
        pgm_config_reset = 1'b1;
        tick();
        pgm_config_reset = 1'b0;
        check("t6_cfgrst_done", 32'(stream_done), 0);
        check("t6_cfgrst_busy", 32'(sch_busy), 1);
        check("t6_cfgrst_addr", 32'(sent_pkt_addr), 0);
        check("t6_err_pre", 32'(sch_err), 0);
        stream_en = 4'b0000;
        wait_idle(1100, cyc, ok);
        check("t6_wdog_fired", 32'(ok), 1);
        check("t6_wdog_cycles", 32'(cyc + 5), 1023);
        check("t6_err", 32'(sch_err), 1);
        pgm_config_reset = 1'b1;
        tick();
        pgm_config_reset = 1'b0;
        check("t6_err_sticky", 32'(sch_err), 1);
        do_reset();
        check("t6_err_rst", 32'(sch_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
